spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
- Parametrised successor to the single-word SPI front end that feeds the tuner display path (SPI -> converter -> LCD controller).
- Receives frames of NUM_CH words, each WORD_W bits, from the MCU over SPI (mode 0, MSB first) and resynchronises them into the clk domain.
- Validates frame length and commits all words atomically to a held output bank.
- Signals an update with a one-cycle pulse; length errors are flagged separately.

Parameters:
- WORD_W, 16, bits per word (e.g. one frequency value).
- NUM_CH, 2, words per frame (channels). Legal range 1..8.
- CS_ACTIVE_LOW, 1, 1 = frame active while cs=0; 0 = frame active while cs=1.
- UPDATE_ON_CHANGE, 0, 1 = suppress new_frame when committed data equals the previous bank.
- SYNC_STAGES, 2, synchroniser flops on sclk, cs and sdi. Minimum 2.

Ports:
- clk, input, 1, system clock (48 MHz HSOSC-derived).
- reset, input, 1, synchronous, active-high.
- sclk, input, 1, SPI clock, asynchronous to clk.
- cs, input, 1, SPI chip select, asynchronous; polarity set by CS_ACTIVE_LOW.
- sdi, input, 1, SPI data in.
- data_out, output, NUM_CH*WORD_W, committed bank; word 0 in the MSBs (first received).
- new_frame, output, 1, one-cycle pulse on a valid commit.
- frame_err, output, 1, one-cycle pulse on a bad-length frame.
- frame_cnt, output, 8, count of valid frames, wraps 255 -> 0.
- busy, output, 1, high while in SHIFT.

Behaviour:
- Clock and reset:
  - Single clk domain. Reset is synchronous and active-high.
  - Reset values: data_out=0, new_frame=0, frame_err=0, frame_cnt=0, busy=0, state=WAIT_IDLE.
- Synchronisation:
  - sclk, cs and sdi each pass through SYNC_STAGES flops plus one history flop for edge detection.
  - Supported sclk frequency is at most clk/8.
- State machine:
  - WAIT_IDLE: wait for synced cs inactive, then go to IDLE. This prevents a partial frame being captured after reset mid-transfer.
  - IDLE: on cs becoming active, clear the shift register and bit counter, go to SHIFT, busy=1.
  - SHIFT: on each synced sclk rising edge, shift in sdi (left shift, MSB first) and increment bit_cnt, which saturates at TOTAL+1, where TOTAL = NUM_CH*WORD_W. On cs becoming inactive, go to CHECK.
  - CHECK (one cycle):
    - If bit_cnt == TOTAL: copy the shift register to data_out, increment frame_cnt, and pulse new_frame. When UPDATE_ON_CHANGE=1 and the shift register equals data_out, frame_cnt still increments but new_frame stays 0.
    - Otherwise: data_out holds its value and frame_err pulses.
    - In both cases go to IDLE.
- Boundary conditions:
  - An sclk rising edge detected in the same cycle as cs deassertion is discarded.
  - Zero-length frame (cs toggles with no sclk) -> frame_err.
  - Frame with more than TOTAL bits -> frame_err. Saturation keeps overflow detectable.
  - new_frame and frame_err are mutually exclusive and never asserted outside CHECK.
  - Latency: new_frame asserts 1 + SYNC_STAGES + 1 clk cycles after the cs deassert edge at the pin; data_out is valid in the same cycle as new_frame.
  - reset asserted in any state returns to WAIT_IDLE within one cycle; an in-flight frame is discarded.

Decomposition:
- Package spi_rx_pkg holds:
  - the state enum (WAIT_IDLE, IDLE, SHIFT, CHECK);
  - MAX_CH=8;
  - a function clog2-based bit counter width: $clog2(TOTAL+2).
- One sub-module, sync_edge: a parametrised SYNC_STAGES synchroniser with rise/fall strobes. Instantiate it three times (sclk, cs, sdi; the sdi instance uses the level output only).

Test Plan:
- Single valid frame: WORD_W=16, NUM_CH=2, send 0x00BD then 0x01B8 -> data_out=0x00BD01B8, one new_frame pulse, frame_cnt=1, frame_err never asserted.
- Short frame: 31 bits then cs deassert -> frame_err pulse, data_out retains its previous value, frame_cnt unchanged.
- Long frame: 33 bits -> frame_err pulse. A following valid 32-bit frame 0xFFFF0000 commits correctly.
- Change suppression: UPDATE_ON_CHANGE=1, send 0x00BD01B8 twice -> first frame gives new_frame=1; second gives new_frame=0 and frame_cnt=2.
- Reset mid-frame: assert reset after 10 bits while cs stays active and sclk continues -> no commit, no error. The block waits for cs inactive, then the next full frame commits normally.
- Wrap and polarity: CS_ACTIVE_LOW=0, send 256 valid frames -> frame_cnt returns to 0, with 256 new_frame pulses.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the multi-word SPI frame receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  localparam int MAX_CH = 8;

  // Bit counter must reach TOTAL+1 so an overlong frame stays distinguishable.
  function automatic int cnt_width(input int total);
    return $clog2(total + 2);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall strobes
// derived from one extra history flop.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              hist_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_reg <= '0;
      hist_reg  <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      hist_reg  <= chain_reg[STAGES-1];
    end
  end

  assign level = chain_reg[STAGES-1];
  assign rise  = level & ~hist_reg;
  assign fall  = ~level & hist_reg;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: shifts NUM_CH words of WORD_W bits, checks the
// frame length on chip-select release and commits the whole bank at once.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int WORD_W           = 16,
  parameter int NUM_CH           = 2,
  parameter int CS_ACTIVE_LOW    = 1,
  parameter int UPDATE_ON_CHANGE = 0,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     cs,
  input  logic                     sdi,
  output logic [NUM_CH*WORD_W-1:0] data_out,
  output logic                     new_frame,
  output logic                     frame_err,
  output logic [7:0]               frame_cnt,
  output logic                     busy
);

  localparam int TOTAL = NUM_CH * WORD_W;
  localparam int CNT_W = cnt_width(TOTAL);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_lvl;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset(reset), .din(sdi),
    .level(sdi_lvl), .rise(), .fall()
  );

  logic cs_act, cs_on, cs_off;
  assign cs_act = (CS_ACTIVE_LOW != 0) ? ~cs_lvl : cs_lvl;
  assign cs_on  = (CS_ACTIVE_LOW != 0) ? cs_fall : cs_rise;
  assign cs_off = (CS_ACTIVE_LOW != 0) ? cs_rise : cs_fall;

  state_t state_reg, state_next;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= WAIT_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_IDLE: if (!cs_act) state_next = IDLE;
      IDLE:      if (cs_on)   state_next = SHIFT;
      SHIFT:     if (cs_off)  state_next = CHECK;
      CHECK:                  state_next = IDLE;
      default:                state_next = WAIT_IDLE;
    endcase
  end

  logic [TOTAL-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [TOTAL-1:0] data_reg;
  logic             new_frame_reg;
  logic             frame_err_reg;
  logic [7:0]       frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      data_reg      <= '0;
      new_frame_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      frame_cnt_reg <= 8'd0;
    end else begin
      new_frame_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cs_on) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          // A clock edge coinciding with chip-select release is not part of the frame.
          if (!cs_off && sclk_rise) begin
            shift_reg <= (shift_reg << 1) | TOTAL'(sdi_lvl);
            if (bit_cnt_reg != CNT_SAT) bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end
        CHECK: begin
          if (bit_cnt_reg == CNT_FULL) begin
            data_reg      <= shift_reg;
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
            new_frame_reg <= !((UPDATE_ON_CHANGE != 0) && (shift_reg == data_reg));
          end else begin
            frame_err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out  = data_reg;
  assign new_frame = new_frame_reg;
  assign frame_err = frame_err_reg;
  assign frame_cnt = frame_cnt_reg;
  assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: default, change-suppressing and
// active-high chip-select instances share sclk/sdi/reset.
module tb_spi_frame_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic cs_p = 1'b0;
  logic sdi = 1'b0;

  logic [31:0] data_a, data_u, data_p;
  logic        nf_a, nf_u, nf_p;
  logic        fe_a, fe_u, fe_p;
  logic [7:0]  cnt_a, cnt_u, cnt_p;
  logic        busy_a, busy_u, busy_p;

  always #5 clk = ~clk;

  spi_frame_rx dut_a (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs_n), .sdi(sdi),
    .data_out(data_a), .new_frame(nf_a), .frame_err(fe_a),
    .frame_cnt(cnt_a), .busy(busy_a)
  );

  spi_frame_rx #(.UPDATE_ON_CHANGE(1)) dut_u (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs_n), .sdi(sdi),
    .data_out(data_u), .new_frame(nf_u), .frame_err(fe_u),
    .frame_cnt(cnt_u), .busy(busy_u)
  );

  spi_frame_rx #(.CS_ACTIVE_LOW(0)) dut_p (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs_p), .sdi(sdi),
    .data_out(data_p), .new_frame(nf_p), .frame_err(fe_p),
    .frame_cnt(cnt_p), .busy(busy_p)
  );

  int checks = 0;
  int failures = 0;
  int nf_a_cnt = 0, fe_a_cnt = 0;
  int nf_u_cnt = 0;
  int nf_p_cnt = 0, fe_p_cnt = 0;
  int excl_viol = 0;

  always @(negedge clk) begin
    if (nf_a) nf_a_cnt++;
    if (fe_a) fe_a_cnt++;
    if (nf_u) nf_u_cnt++;
    if (nf_p) nf_p_cnt++;
    if (fe_p) fe_p_cnt++;
    if ((nf_a && fe_a) || (nf_u && fe_u) || (nf_p && fe_p)) excl_viol++;
  end

  // Stimulus helpers; all edges land on falling clk edges.
  task automatic start_frame(input bit pol);
    @(negedge clk);
    if (pol) cs_p = 1'b1; else cs_n = 1'b0;
    #40;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input bit pol);
    #40;
    if (pol) cs_p = 1'b0; else cs_n = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] v, input int n, input bit pol);
    start_frame(pol);
    send_bits(v, n);
    end_frame(pol);
    settle();
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=%h", data_a, 32'h0); end
    checks++; if (cnt_a !== 8'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (nf_a !== 1'b0 || fe_a !== 1'b0) begin failures++; $display("FAIL reset_pulses got nf=%b fe=%b exp 0/0", nf_a, fe_a); end
    reset = 1'b0;
    settle();
  endtask

  task automatic test_single_frame();
    int n0, e0, lat;
    n0 = nf_a_cnt; e0 = fe_a_cnt; lat = 0;
    start_frame(0);
    send_bits(64'h00BD, 16);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy_a); end
    send_bits(64'h01B8, 16);
    end_frame(0);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (nf_a) lat = k;
    end
    checks++; if (lat != 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", lat); end
    checks++; if (data_a !== 32'h00BD01B8) begin failures++; $display("FAIL single_data got=%h exp=00bd01b8", data_a); end
    settle();
    checks++; if (cnt_a !== 8'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", cnt_a); end
    checks++; if (nf_a_cnt - n0 != 1) begin failures++; $display("FAIL single_nf_pulses got=%0d exp=1", nf_a_cnt - n0); end
    checks++; if (fe_a_cnt - e0 != 0) begin failures++; $display("FAIL single_fe_pulses got=%0d exp=0", fe_a_cnt - e0); end
  endtask

  task automatic test_short_frame();
    int n0, e0;
    n0 = nf_a_cnt; e0 = fe_a_cnt;
    send_frame(64'h091A2B3C, 31, 0);
    checks++; if (fe_a_cnt - e0 != 1) begin failures++; $display("FAIL short_fe got=%0d exp=1", fe_a_cnt - e0); end
    checks++; if (nf_a_cnt - n0 != 0) begin failures++; $display("FAIL short_nf got=%0d exp=0", nf_a_cnt - n0); end
    checks++; if (data_a !== 32'h00BD01B8) begin failures++; $display("FAIL short_data got=%h exp=00bd01b8", data_a); end
    checks++; if (cnt_a !== 8'd1) begin failures++; $display("FAIL short_cnt got=%0d exp=1", cnt_a); end
  endtask

  task automatic test_long_frame();
    int n0, e0;
    n0 = nf_a_cnt; e0 = fe_a_cnt;
    send_frame(64'h1_2345_6789, 33, 0);
    checks++; if (fe_a_cnt - e0 != 1) begin failures++; $display("FAIL long_fe got=%0d exp=1", fe_a_cnt - e0); end
    checks++; if (data_a !== 32'h00BD01B8) begin failures++; $display("FAIL long_data_held got=%h exp=00bd01b8", data_a); end
    send_frame(64'hFFFF0000, 32, 0);
    checks++; if (data_a !== 32'hFFFF0000) begin failures++; $display("FAIL long_next_data got=%h exp=ffff0000", data_a); end
    checks++; if (cnt_a !== 8'd2) begin failures++; $display("FAIL long_next_cnt got=%0d exp=2", cnt_a); end
    checks++; if (nf_a_cnt - n0 != 1) begin failures++; $display("FAIL long_nf got=%0d exp=1", nf_a_cnt - n0); end
  endtask

  task automatic test_zero_length();
    int e0;
    e0 = fe_a_cnt;
    start_frame(0);
    end_frame(0);
    settle();
    checks++; if (fe_a_cnt - e0 != 1) begin failures++; $display("FAIL zero_fe got=%0d exp=1", fe_a_cnt - e0); end
    checks++; if (cnt_a !== 8'd2) begin failures++; $display("FAIL zero_cnt got=%0d exp=2", cnt_a); end
  endtask

  task automatic test_reset_mid_frame();
    int n0, e0;
    start_frame(0);
    send_bits(64'h2AB, 10);
    pulse_reset();
    n0 = nf_a_cnt; e0 = fe_a_cnt;
    send_bits(64'h155, 11);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_a); end
    send_bits(64'h2AA, 11);
    end_frame(0);
    settle();
    checks++; if (nf_a_cnt - n0 != 0 || fe_a_cnt - e0 != 0) begin failures++; $display("FAIL midrst_pulses got nf=%0d fe=%0d exp 0/0", nf_a_cnt - n0, fe_a_cnt - e0); end
    checks++; if (data_a !== 32'h0 || cnt_a !== 8'd0) begin failures++; $display("FAIL midrst_state got data=%h cnt=%0d exp 0/0", data_a, cnt_a); end
    send_frame(64'h00BD01B8, 32, 0);
    checks++; if (data_a !== 32'h00BD01B8 || cnt_a !== 8'd1) begin failures++; $display("FAIL midrst_next got data=%h cnt=%0d exp 00bd01b8/1", data_a, cnt_a); end
    checks++; if (nf_a_cnt - n0 != 1) begin failures++; $display("FAIL midrst_next_nf got=%0d exp=1", nf_a_cnt - n0); end
  endtask

  task automatic test_change_suppression();
    int u0;
    pulse_reset();
    settle();
    u0 = nf_u_cnt;
    send_frame(64'h00BD01B8, 32, 0);
    checks++; if (nf_u_cnt - u0 != 1) begin failures++; $display("FAIL uoc_first_nf got=%0d exp=1", nf_u_cnt - u0); end
    send_frame(64'h00BD01B8, 32, 0);
    checks++; if (nf_u_cnt - u0 != 1) begin failures++; $display("FAIL uoc_second_nf got=%0d exp=1", nf_u_cnt - u0); end
    checks++; if (cnt_u !== 8'd2) begin failures++; $display("FAIL uoc_cnt got=%0d exp=2", cnt_u); end
    checks++; if (data_u !== 32'h00BD01B8) begin failures++; $display("FAIL uoc_data got=%h exp=00bd01b8", data_u); end
  endtask

  task automatic test_wrap_polarity();
    int p0, e0;
    logic [7:0]  b;
    logic [31:0] v;
    p0 = nf_p_cnt; e0 = fe_p_cnt; v = '0;
    checks++; if (cnt_p !== 8'd0) begin failures++; $display("FAIL wrap_start_cnt got=%0d exp=0", cnt_p); end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      v = {b, ~b, b ^ 8'h5A, 8'hC3};
      send_frame({32'h0, v}, 32, 1);
      if (i == 254) begin
        checks++; if (cnt_p !== 8'd255) begin failures++; $display("FAIL wrap_cnt_255 got=%0d exp=255", cnt_p); end
      end
    end
    checks++; if (cnt_p !== 8'd0) begin failures++; $display("FAIL wrap_cnt_0 got=%0d exp=0", cnt_p); end
    checks++; if (nf_p_cnt - p0 != 256) begin failures++; $display("FAIL wrap_nf got=%0d exp=256", nf_p_cnt - p0); end
    checks++; if (fe_p_cnt - e0 != 0) begin failures++; $display("FAIL wrap_fe got=%0d exp=0", fe_p_cnt - e0); end
    checks++; if (data_p !== 32'hFF00A5C3) begin failures++; $display("FAIL wrap_data got=%h exp=ff00a5c3", data_p); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_short_frame();
    test_long_frame();
    test_zero_length();
    test_reset_mid_frame();
    test_change_suppression();
    test_wrap_polarity();
    checks++; if (excl_viol != 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", excl_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
